seven_seg_scanner: RTL

//  Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-anode digits.

---
 rtl/seg_pkg.sv | 13 +
 rtl/seven_seg_scanner_decode.sv | 32 +++
 rtl/seven_seg_scanner.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: FSM state encoding and
// the all-segments-off pattern (segments are active-low, g..a).
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seven_seg_scanner_decode.sv
// Hex nibble to 7-segment pattern, segments ordered g..a, active-low.
module nibbleDecode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display driver: one shared decoder, blank gaps
// between digits, leading-zero blanking and frame-synchronous value updates.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIV          = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int unsigned MAX_CNT = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [4*NUM_DIGITS-1:0] shad_val_q, disp_val_q;
  logic [NUM_DIGITS-1:0]   shad_dp_q, disp_dp_q;
  logic                    shad_lz_q, disp_lz_q;
  logic                    pending_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   dig_sel_q;
  logic                    frame_done_q;

  logic                    last_tick, last_digit, advance, frame_start;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   lz_mask;

  assign last_tick  = (cnt_q == '0);
  assign last_digit = (idx_q == IDX_LAST);
  // Without a gap the digit advances straight out of SHOW.
  assign advance    = last_tick && ((BLANK_CYCLES == 0) ? (state_q == SHOW) : (state_q == GAP));
  assign frame_start = enable && ((state_q == IDLE) || (advance && last_digit));

  assign nibble = disp_val_q[{idx_q, 2'b00} +: 4];

  nibbleDecode u_dec (
    .nibble (nibble),
    .seg_n  (dec_seg)
  );

  always_comb begin
    lz_mask = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      lz_mask[i] = disp_lz_q && ((disp_val_q >> (4 * i)) == '0) && !disp_dp_q[i];
    end
  end

  // A load on the frame-start edge bypasses the shadow so that frame uses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shad_val_q <= '0;
      shad_dp_q  <= '0;
      shad_lz_q  <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      disp_lz_q  <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      if (load) begin
        shad_val_q <= value;
        shad_dp_q  <= dp_in;
        shad_lz_q  <= lz_blank;
        pending_q  <= 1'b1;
      end
      if (frame_start && (load || pending_q)) begin
        disp_val_q <= load ? value    : shad_val_q;
        disp_dp_q  <= load ? dp_in    : shad_dp_q;
        disp_lz_q  <= load ? lz_blank : shad_lz_q;
        pending_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      dig_sel_q    <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      dig_sel_q    <= '1;
      if (enable && (state_q == SHOW)) begin
        dig_sel_q <= ~(NUM_DIGITS'(1) << idx_q);
        if (!lz_mask[idx_q]) begin
          seg_q <= dec_seg;
          dp_q  <= ~disp_dp_q[idx_q];
        end
      end

      if (!enable) begin
        state_q <= IDLE;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= SHOW;
            idx_q   <= '0;
            cnt_q   <= DIV_LD;
          end
          SHOW, GAP: begin
            if (!last_tick) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else if ((state_q == SHOW) && (BLANK_CYCLES != 0)) begin
              state_q <= GAP;
              cnt_q   <= GAP_LD;
            end else begin
              state_q      <= SHOW;
              cnt_q        <= DIV_LD;
              idx_q        <= last_digit ? '0 : idx_q + IDX_W'(1);
              frame_done_q <= last_digit;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule
